// File: rtl/ifconv_sched_pkg.sv
// rtl/ifconv_sched_pkg.sv - shared encodings and tracking entry for the conversion scheduler
package ifconv_sched_pkg;

  localparam logic [1:0] MODE_SNG = 2'd0;
  localparam logic [1:0] MODE_DBL = 2'd1;
  localparam logic [1:0] MODE_EXT = 2'd2;
  localparam logic [1:0] MODE_ILL = 2'd3;

  localparam logic [1:0] ptype_sng = 2'd0;
  localparam logic [1:0] ptype_dbl = 2'd1;
  localparam logic [1:0] ptype_ext = 2'd2;

  localparam int TRK_TAG_W = 9;

  typedef struct packed {
    logic                 vld;
    logic [TRK_TAG_W-1:0] tag;
    logic                 src;
    logic                 err;
  } trk_t;

  // Returns {toEXT, toDBL, toSNG}; the illegal mode raises no strobe.
  function automatic logic [2:0] mode_strobes(input logic [1:0] mode);
    case (mode)
      MODE_SNG: mode_strobes = 3'b001;
      MODE_DBL: mode_strobes = 3'b010;
      MODE_EXT: mode_strobes = 3'b100;
      default:  mode_strobes = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ifconv_sched_fifo.sv
// rtl/ifconv_sched_fifo.sv - DEPTH x W synchronous FIFO with count output and clock-enable gating
module ifconv_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          not_empty,
  output logic [CW-1:0] cnt
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clk_en) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && push) mem[wr_ptr] <= wdata;
  end

  assign not_empty = (cnt != '0);
  assign rdata     = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifconv_sched.sv
// rtl/ifconv_sched.sv - round-robin scheduler sharing one int-to-float pipe between two requesters
module ifconv_sched
  import ifconv_sched_pkg::*;
#(
  parameter int TAG_W = TRK_TAG_W,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             req0_vld,
  input  logic [64:0]      req0_A,
  input  logic             req0_isS,
  input  logic [1:0]       req0_mode,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_gnt,
  input  logic             req1_vld,
  input  logic [64:0]      req1_A,
  input  logic             req1_isS,
  input  logic [1:0]       req1_mode,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_gnt,
  output logic             cnv_en,
  output logic [64:0]      cnv_A,
  output logic             cnv_isS,
  output logic             cnv_toSNG,
  output logic             cnv_toDBL,
  output logic             cnv_toEXT,
  input  logic [81:0]      cnv_res,
  input  logic [1:0]       cnv_rtyp,
  output logic             out_vld,
  output logic [81:0]      out_res,
  output logic [1:0]       out_rtyp,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src,
  output logic             out_err,
  input  logic             out_rdy,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = 82 + 2 + TAG_W + 2;

  trk_t          stage [LAT];
  trk_t          new_entry;
  logic          rr;
  logic          credit_ok;
  logic          issue_ok;
  logic          win;
  logic [1:0]    sel_mode;
  logic [2:0]    strobes;
  logic [CW-1:0] inflight_cnt;
  logic [CW-1:0] fifo_cnt;
  logic          push;
  logic          pop;
  logic [FW-1:0] wdata;
  logic [FW-1:0] rdata;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < LAT; i++) inflight_cnt = inflight_cnt + CW'(stage[i].vld);
  end

  // A pop in the same cycle is deliberately not credited back.
  assign credit_ok = (int'(fifo_cnt) + int'(inflight_cnt) + 1) <= DEPTH;
  assign issue_ok  = clkEn & ~rst & credit_ok;

  always_comb begin
    req0_gnt  = issue_ok & req0_vld & (~req1_vld | ~rr);
    req1_gnt  = issue_ok & req1_vld & (~req0_vld | rr);
    cnv_en    = req0_gnt | req1_gnt;
    win       = req1_gnt;
    sel_mode  = win ? req1_mode : req0_mode;
    cnv_A     = win ? req1_A : req0_A;
    cnv_isS   = win ? req1_isS : req0_isS;
    strobes   = cnv_en ? mode_strobes(sel_mode) : 3'b000;
    cnv_toSNG = strobes[0];
    cnv_toDBL = strobes[1];
    cnv_toEXT = strobes[2];
    new_entry.vld = cnv_en;
    new_entry.tag = win ? req1_tag : req0_tag;
    new_entry.src = win;
    new_entry.err = (sel_mode == MODE_ILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= 1'b0;
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else if (clkEn) begin
      stage[0] <= new_entry;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
      if (cnv_en) rr <= ~win;
    end
  end

  // Illegal-mode slots still flow through so result order matches grant order.
  assign push  = clkEn & stage[LAT-1].vld;
  assign wdata = stage[LAT-1].err
               ? {82'd0, ptype_sng, stage[LAT-1].tag, stage[LAT-1].src, 1'b1}
               : {cnv_res, cnv_rtyp, stage[LAT-1].tag, stage[LAT-1].src, 1'b0};
  assign pop   = out_vld & out_rdy;

  ifconv_sched_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clkEn),
    .push      (push),
    .wdata     (wdata),
    .pop       (pop),
    .rdata     (rdata),
    .not_empty (out_vld),
    .cnt       (fifo_cnt)
  );

  assign {out_res, out_rtyp, out_tag, out_src, out_err} = rdata;
  assign busy = (inflight_cnt != '0) | out_vld;

endmodule
